uart_frame_tx: RTL

UART_FRAME_TX -- requirements
Module: uart_frame_tx

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_frame_tx.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART frame transmit path.
// Mode and frame-state encodings plus the default start marker.
package uart_pkg;

  typedef enum logic [1:0] {
    MODE_MIXED    = 2'b00,
    MODE_RAW      = 2'b01,
    MODE_ENC      = 2'b10,
    MODE_RESERVED = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_MODE,
    ST_HDR,
    ST_PAYLOAD,
    ST_CKSUM
  } state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_tx.sv
// Frames a header and payload into a byte stream for uart_tx:
// sync, mode, header, payload and an XOR checksum.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int         MESSAGE_SIZE = 512,
  parameter int         HEADER_SIZE  = 32,
  parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic [MESSAGE_SIZE-1:0] encrypted_in,
  input  logic [MESSAGE_SIZE-1:0] decrypted_in,
  input  logic [HEADER_SIZE-1:0]  header_in,
  input  logic [1:0]              mode_in,
  output logic [7:0]              byte_out,
  output logic                    byte_valid_out,
  input  logic                    byte_ready_in,
  output logic                    error_out,
  output logic [15:0]             frames_sent_out
);

  localparam int PB = MESSAGE_SIZE / 8;
  localparam int HB = HEADER_SIZE / 8;
  localparam int CW = $clog2(2 * PB + 1);
  localparam int PW = 2 * MESSAGE_SIZE;
  localparam logic [CW-1:0] HDR_LAST = CW'(HB - 1);

  state_e state_q, state_d;

  logic                   armed_q;
  logic [1:0]             mode_q;
  logic [HEADER_SIZE-1:0] hdr_q;
  logic [PW-1:0]          pay_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          pay_last_q;
  logic [7:0]             cksum_q;
  logic [15:0]            frames_q;
  logic                   accept;
  logic                   hs;

  // armed_q keeps ready low until the first edge after reset release
  assign ready_out       = armed_q && (state_q == ST_IDLE);
  assign accept          = valid_in && ready_out;
  assign byte_valid_out  = (state_q != ST_IDLE);
  assign hs              = byte_valid_out && byte_ready_in;
  assign frames_sent_out = frames_q;

  always_comb begin
    state_d  = state_q;
    byte_out = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (accept && mode_in != MODE_RESERVED)
          state_d = ST_SYNC;
      end
      ST_SYNC: begin
        byte_out = SYNC_BYTE;
        if (byte_ready_in) state_d = ST_MODE;
      end
      ST_MODE: begin
        byte_out = {6'b0, mode_q};
        if (byte_ready_in) state_d = ST_HDR;
      end
      ST_HDR: begin
        byte_out = hdr_q[HEADER_SIZE-1 -: 8];
        if (byte_ready_in && cnt_q == HDR_LAST)
          state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        byte_out = pay_q[PW-1 -: 8];
        if (byte_ready_in && cnt_q == pay_last_q)
          state_d = ST_CKSUM;
      end
      ST_CKSUM: begin
        byte_out = cksum_q;
        if (byte_ready_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      armed_q    <= 1'b0;
      error_out  <= 1'b0;
      mode_q     <= 2'b00;
      hdr_q      <= '0;
      pay_q      <= '0;
      cnt_q      <= '0;
      pay_last_q <= '0;
      cksum_q    <= 8'h00;
      frames_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      armed_q   <= 1'b1;
      error_out <= accept && (mode_in == MODE_RESERVED);
      if (accept) begin
        mode_q  <= mode_in;
        hdr_q   <= header_in;
        cnt_q   <= '0;
        cksum_q <= 8'h00;
        // payload is left-aligned so bytes always leave from the top
        case (mode_in)
          MODE_MIXED: begin
            pay_q      <= {encrypted_in, decrypted_in};
            pay_last_q <= CW'(2 * PB - 1);
          end
          MODE_RAW: begin
            pay_q      <= {decrypted_in, {MESSAGE_SIZE{1'b0}}};
            pay_last_q <= CW'(PB - 1);
          end
          default: begin
            pay_q      <= {encrypted_in, {MESSAGE_SIZE{1'b0}}};
            pay_last_q <= CW'(PB - 1);
          end
        endcase
      end else if (hs) begin
        case (state_q)
          ST_MODE: cksum_q <= cksum_q ^ byte_out;
          ST_HDR: begin
            cksum_q <= cksum_q ^ byte_out;
            hdr_q   <= hdr_q << 8;
            cnt_q   <= (cnt_q == HDR_LAST) ? '0 : cnt_q + CW'(1);
          end
          ST_PAYLOAD: begin
            cksum_q <= cksum_q ^ byte_out;
            pay_q   <= pay_q << 8;
            cnt_q   <= (cnt_q == pay_last_q) ? '0 : cnt_q + CW'(1);
          end
          ST_CKSUM: frames_q <= frames_q + 16'd1;
          default: ;
        endcase
      end
    end
  end

endmodule
